mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction-fetch and
// load/store channels. One transaction is outstanding at a time, conflicts are
// resolved round-robin, and read data is steered back to whoever asked for it.
// Three free-running counters feed the performance-counter bank.

module mem_port_arbiter (
   input  logic        clk,
   input  logic        rst,

   input  logic [31:0] if_addr,
   input  logic        if_req_valid,
   output logic        if_req_ready,
   output logic [31:0] if_rdata,
   output logic        if_rdata_valid,
   input  logic        if_rdata_ready,

   input  logic [31:0] d_addr,
   input  logic        d_ren,
   input  logic        d_wen,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_req_ready,
   output logic [31:0] d_rdata,
   output logic        d_rdata_valid,
   input  logic        d_rdata_ready,

   output logic [31:0] mem_addr,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_req_ready,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rdata_valid,
   output logic        mem_rdata_ready,

   output logic [31:0] cnt_if_grant,
   output logic [31:0] cnt_d_grant,
   output logic [31:0] cnt_conflict
);

   typedef enum logic [5:0] {
      IDLE    = 6'b000001,
      REQ_IF  = 6'b000010,
      REQ_DR  = 6'b000100,
      REQ_DW  = 6'b001000,
      RESP_IF = 6'b010000,
      RESP_D  = 6'b100000
   } state_e;

   // Which requester won the most recent conflict; DATA after reset so the
   // very first conflict is handed to fetch.
   typedef enum logic {
      GRANT_IF   = 1'b0,
      GRANT_DATA = 1'b1
   } grant_e;

   state_e      state_q, state_d;
   grant_e      lastGrant_q, lastGrant_d;
   logic [31:0] cntIfGrant_q, cntDGrant_q, cntConflict_q;

   logic ifPending, dPending, dIsWrite;
   logic ifHandshake, dHandshake;

   assign ifPending = if_req_valid;
   assign dPending  = d_ren | d_wen;
   // A request with both read and write asserted is handled as a write.
   assign dIsWrite  = d_wen;

   assign ifHandshake = (state_q == REQ_IF) & mem_req_ready;
   assign dHandshake  = ((state_q == REQ_DR) | (state_q == REQ_DW)) & mem_req_ready;

   // State and round-robin history register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         lastGrant_q <= GRANT_DATA;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
      end
   end

   // Next-state logic; arbitration only happens from IDLE, so requests that
   // show up mid-transaction simply wait their turn.
   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      case (state_q)
         IDLE: begin
            if (ifPending && dPending) begin
               if (lastGrant_q == GRANT_DATA) begin
                  state_d     = REQ_IF;
                  lastGrant_d = GRANT_IF;
               end else begin
                  state_d     = dIsWrite ? REQ_DW : REQ_DR;
                  lastGrant_d = GRANT_DATA;
               end
            end else if (ifPending) begin
               state_d = REQ_IF;
            end else if (dPending) begin
               state_d = dIsWrite ? REQ_DW : REQ_DR;
            end
         end
         REQ_IF:  if (mem_req_ready) state_d = RESP_IF;
         REQ_DR:  if (mem_req_ready) state_d = RESP_D;
         REQ_DW:  if (mem_req_ready) state_d = IDLE;
         RESP_IF: if (mem_rdata_valid && if_rdata_ready) state_d = IDLE;
         RESP_D:  if (mem_rdata_valid && d_rdata_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode: the granted requester drives the memory port, and read
   // responses pass straight through to the owner of the outstanding read.
   always_comb begin
      mem_addr        = '0;
      mem_ren         = 1'b0;
      mem_wen         = 1'b0;
      mem_wdata       = '0;
      mem_wstrb       = '0;
      if_req_ready    = 1'b0;
      d_req_ready     = 1'b0;
      if_rdata_valid  = 1'b0;
      d_rdata_valid   = 1'b0;
      mem_rdata_ready = 1'b0;
      case (state_q)
         REQ_IF: begin
            mem_addr     = if_addr;
            mem_ren      = 1'b1;
            if_req_ready = mem_req_ready;
         end
         REQ_DR: begin
            mem_addr    = d_addr;
            mem_ren     = 1'b1;
            d_req_ready = mem_req_ready;
         end
         REQ_DW: begin
            mem_addr    = d_addr;
            mem_wen     = 1'b1;
            mem_wdata   = d_wdata;
            mem_wstrb   = d_wstrb;
            d_req_ready = mem_req_ready;
         end
         RESP_IF: begin
            if_rdata_valid  = mem_rdata_valid;
            mem_rdata_ready = if_rdata_ready;
         end
         RESP_D: begin
            d_rdata_valid   = mem_rdata_valid;
            mem_rdata_ready = d_rdata_ready;
         end
         default: ;
      endcase
   end

   // Read data is shared by both channels; it is forced to zero while reset
   // is held so that every output reads zero during reset.
   assign if_rdata = rst ? mem_rdata : '0;
   assign d_rdata  = rst ? mem_rdata : '0;

   // Performance counters; they wrap naturally at 32 bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cntIfGrant_q  <= '0;
         cntDGrant_q   <= '0;
         cntConflict_q <= '0;
      end else begin
         if (ifHandshake)          cntIfGrant_q  <= cntIfGrant_q + 32'd1;
         if (dHandshake)           cntDGrant_q   <= cntDGrant_q + 32'd1;
         if (ifPending & dPending) cntConflict_q <= cntConflict_q + 32'd1;
      end
   end

   assign cnt_if_grant = cntIfGrant_q;
   assign cnt_d_grant  = cntDGrant_q;
   assign cnt_conflict = cntConflict_q;

endmodule
